serial_code_sender: RTL and testbench
=====================================

# serial_code_sender

Upstream feed stage for the 4-flop serial sequence detector. It latches a 4-bit code from the input switches and shifts it out MSB-first, one bit per clock, on a single serial line. That line is wired to the detector's data input, and both blocks share one clock. After each code the block inserts a fixed run of zero gap cycles so the detector settles back to its idle state. An optional repeat mode re-sends the latched code back-to-back.

## Interface
Parameters:
- GAP_CYCLES, default 3: zero cycles inserted after each code; legal range 1..15; 0 is illegal.
- CODE_W, default 4: code width; fixed at 4 by pin budget; sourced from the package.

Ports (TinyTapeout-style `io_in`/`io_out` bit fields). Clock is one domain; reset is synchronous and active-high.
- `io_in[0]`, in, 1: `clk`, the only clock.
- `io_in[1]`, in, 1: `rst`, synchronous, active-high.
- `io_in[2]`, in, 1: `start`, level input; the rising edge is detected internally.
- `io_in[6:3]`, in, 4: `code`, latched only on an accepted start.
- `io_in[7]`, in, 1: `repeat`, sampled at each frame end.
- `io_out[0]`, out, 1: `sdata`, serial bit to the detector.
- `io_out[1]`, out, 1: `valid`, high while `sdata` carries a code bit.
- `io_out[2]`, out, 1: `busy`, high in SHIFT or GAP.
- `io_out[3]`, out, 1: `done`, one-cycle pulse at each frame end.
- `io_out[5:4]`, out, 2: `bit_idx`, index of the bit currently on `sdata` (3..0); 0 when not shifting.
- `io_out[7:6]`, out, 2: `frame_cnt`, frames completed, mod 4.

## Operation
- All outputs are registered.
- **Reset:** every output is 0, state is IDLE, the shift register, gap counter, `frame_cnt` and `start_q` are all 0.
- **Start detect:** `start_q` registers `start` every cycle, including while busy. `start_pulse = start & ~start_q`.
- **IDLE:**
  - `sdata`, `valid`, `busy` are 0.
  - On `start_pulse`: latch `code` into `code_l` and `shreg`, go to SHIFT, `bit_idx` = 3.
- **SHIFT:**
  - `sdata = shreg[3]`, `valid` = 1, `busy` = 1.
  - Each cycle: shift `shreg` left, decrement `bit_idx`.
  - After the cycle with `bit_idx` = 0: go to GAP, gap counter = GAP_CYCLES-1.
- **GAP:**
  - `sdata` = 0, `valid` = 0, `busy` = 1.
  - Decrement the gap counter; on reaching 0, the frame ends:
    - `done` = 1 for one cycle and `frame_cnt` increments (wraps 3→0).
    - If `repeat` = 1: reload `shreg` from `code_l`, go to SHIFT with `bit_idx` = 3.
    - Otherwise go to IDLE.
- **Ignored inputs:**
  - `start_pulse` while busy is ignored; no queuing.
  - `code` changes after latch are ignored until the next accepted start.
- **Dropping repeat:** clearing `repeat` mid-frame lets the current frame finish, then the block returns to IDLE.

## Timing
- `start` first seen high at edge k → SHIFT from edge k, so `code[3]` is on `sdata` in cycle k.
- Bits `code[3..0]` occupy cycles k..k+3.
- GAP occupies cycles k+4..k+3+GAP_CYCLES.
- At edge k+4+GAP_CYCLES:
  - `done` = 1 for that one cycle.
  - `frame_cnt` updates.
  - The block is in IDLE, or, with `repeat` = 1, `code[3]` is back on `sdata`.
- Frame period is 4+GAP_CYCLES cycles (default 7). There are no dead cycles between repeated frames.
- A start accepted in the `done` cycle requires `start` to rise at that edge; earliest restart is 1 cycle after IDLE entry.
- Reset asserted at any edge overrides everything. Outputs are 0 in the following cycle and stay 0 while `rst` = 1.

## Structure
- Package `serial_code_pkg` holds:
  - the `state_t` enum {IDLE, SHIFT, GAP};
  - `CODE_W` = 4;
  - the output bit-position constants.
- Sub-module `start_edge_detect` (register plus rising-edge pulse, synchronous reset) is natural. It is reused for other switch-driven blocks.
- Top level: FSM, shift register, gap counter, frame counter.

## Test plan
- **Reset:** hold `rst` = 1 for 2 cycles with random inputs → `io_out` = 8'h00; after release, `io_out` stays 8'h00 with `start` = 0.
- **Single frame:** `code` = 4'b1011, one `start` rise, `repeat` = 0 →
  - `sdata` 1,0,1,1 with `valid` = 1 and `bit_idx` 3,2,1,0;
  - then 3 cycles of `sdata` = 0 with `busy` = 1;
  - then `done` = 1 for 1 cycle and `frame_cnt` = 1.
- **Level start:** hold `start` high for 20 cycles → exactly one frame and one `done`.
- **Repeat:** `code` = 4'b0110 with `repeat` = 1 → frames every 7 cycles with no gap in `busy`; `frame_cnt` goes 1,2,3,0. Clear `repeat` during the 5th frame's SHIFT → that frame completes, then IDLE.
- **Busy-time changes:** during SHIFT, toggle `start` and change `code` to 4'b0000 → the serialized bits still match the latched code, and no extra frame follows.
- **Reset mid-frame:** assert `rst` during the 2nd bit → `io_out` = 8'h00 the next cycle; a new `start` with `code` = 4'b1111 then produces a full frame and `frame_cnt` = 1.

Source files
------------

// File: rtl/serial_code_pkg.sv
// serial_code_pkg
//   Shared types and constants for serial_code_sender.
//   - state_t   : sender FSM states
//   - CODE_W    : width of the serialized code (bounded by the pin budget)
//   - IN_* / OUT_* : bit positions inside the io_in / io_out pin bundles
package serial_code_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int CODE_W = 4;

   // io_in bit positions
   localparam int IN_CLK     = 0;
   localparam int IN_RST     = 1;
   localparam int IN_START   = 2;
   localparam int IN_CODE_LO = 3;
   localparam int IN_REPEAT  = 7;

   // io_out bit positions
   localparam int OUT_SDATA   = 0;
   localparam int OUT_VALID   = 1;
   localparam int OUT_BUSY    = 2;
   localparam int OUT_DONE    = 3;
   localparam int OUT_BIDX_LO = 4;
   localparam int OUT_FCNT_LO = 6;

endpackage

// File: rtl/start_edge_detect.sv
// start_edge_detect
//   Registers a level input every cycle and produces a combinational
//   rising-edge pulse (level high now, low on the previous cycle).
// Ports:
//   clk   - clock
//   rst   - synchronous, active-high reset (clears the history flop)
//   level - switch level to watch
//   rise  - high for the cycle in which level is first seen high
module start_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic level_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/serial_code_sender.sv
// serial_code_sender
//   Latches a 4-bit code on a rising start and shifts it out MSB-first on a
//   single serial line, followed by GAP_CYCLES zero cycles. With repeat high
//   at the end of a frame the latched code is re-sent with no dead cycle.
// Parameters:
//   GAP_CYCLES - zero cycles after each code, legal range 1..15
// Ports (pin bundles):
//   io_in[0]   clk        io_out[0]   sdata
//   io_in[1]   rst        io_out[1]   valid
//   io_in[2]   start      io_out[2]   busy
//   io_in[6:3] code       io_out[3]   done
//   io_in[7]   repeat     io_out[5:4] bit_idx
//                         io_out[7:6] frame_cnt
// Stream semantics: there is no back-pressure. valid is high exactly in the
// cycles where sdata carries a code bit; the receiver must take that bit in
// that cycle. bit_idx names which code bit is on sdata while valid is high.
module serial_code_sender
   import serial_code_pkg::*;
#(
   parameter int GAP_CYCLES = 3
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam logic [1:0] BIT_MSB  = 2'(CODE_W - 1);
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   logic              clk;
   logic              rst;
   logic              start;
   logic [CODE_W-1:0] code;
   logic              repeat_en;
   logic              start_pulse;

   assign clk       = io_in[IN_CLK];
   assign rst       = io_in[IN_RST];
   assign start     = io_in[IN_START];
   assign code      = io_in[IN_CODE_LO +: CODE_W];
   assign repeat_en = io_in[IN_REPEAT];

   start_edge_detect u_start_edge (
      .clk   (clk),
      .rst   (rst),
      .level (start),
      .rise  (start_pulse)
   );

   state_t            state, state_n;
   logic [CODE_W-1:0] code_l, code_l_n;
   logic [CODE_W-1:0] shreg, shreg_n;
   logic [1:0]        bit_idx, bit_idx_n;
   logic [3:0]        gap_cnt, gap_cnt_n;
   logic [1:0]        frame_cnt, frame_cnt_n;
   logic              done_n;
   logic [7:0]        out_n, out_q;

   always_comb begin
      state_n     = state;
      code_l_n    = code_l;
      shreg_n     = shreg;
      bit_idx_n   = bit_idx;
      gap_cnt_n   = gap_cnt;
      frame_cnt_n = frame_cnt;
      done_n      = 1'b0;

      case (state)
         IDLE: begin
            if (start_pulse) begin
               code_l_n  = code;
               shreg_n   = code;
               bit_idx_n = BIT_MSB;
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            shreg_n = {shreg[CODE_W-2:0], 1'b0};
            if (bit_idx == 2'd0) begin
               gap_cnt_n = GAP_LOAD;
               state_n   = GAP;
            end else begin
               bit_idx_n = bit_idx - 2'd1;
            end
         end
         GAP: begin
            if (gap_cnt == 4'd0) begin
               // Frame end: repeat is sampled only here, so dropping it
               // mid-frame lets the current frame finish first.
               done_n      = 1'b1;
               frame_cnt_n = frame_cnt + 2'd1;
               if (repeat_en) begin
                  shreg_n   = code_l;
                  bit_idx_n = BIT_MSB;
                  state_n   = SHIFT;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               gap_cnt_n = gap_cnt - 4'd1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Outputs are decoded from next-state values and registered, so each
   // pin reflects the state entered at the same edge with no glitches.
   always_comb begin
      out_n                       = '0;
      out_n[OUT_SDATA]            = (state_n == SHIFT) & shreg_n[CODE_W-1];
      out_n[OUT_VALID]            = (state_n == SHIFT);
      out_n[OUT_BUSY]             = (state_n != IDLE);
      out_n[OUT_DONE]             = done_n;
      out_n[OUT_BIDX_LO +: 2]     = (state_n == SHIFT) ? bit_idx_n : 2'd0;
      out_n[OUT_FCNT_LO +: 2]     = frame_cnt_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         code_l    <= '0;
         shreg     <= '0;
         bit_idx   <= 2'd0;
         gap_cnt   <= 4'd0;
         frame_cnt <= 2'd0;
         out_q     <= 8'h00;
      end else begin
         state     <= state_n;
         code_l    <= code_l_n;
         shreg     <= shreg_n;
         bit_idx   <= bit_idx_n;
         gap_cnt   <= gap_cnt_n;
         frame_cnt <= frame_cnt_n;
         out_q     <= out_n;
      end
   end

   assign io_out = out_q;

endmodule

// File: tb/tb_serial_code_sender.sv
// tb_serial_code_sender
//   Directed bench for serial_code_sender with GAP_CYCLES = 3.
//   io_out layout: {frame_cnt[1:0], bit_idx[1:0], done, busy, valid, sdata}.
module tb_serial_code_sender;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       rpt;
   logic [3:0] code;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] exp_f;

   assign io_in = {rpt, code, start, rst, clk};

   serial_code_sender #(.GAP_CYCLES(3)) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- helpers
   function automatic logic [7:0] mk(input logic [1:0] f, input logic [1:0] b,
                                     input logic d, input logic bs,
                                     input logic v, input logic s);
      return {f, b, d, bs, v, s};
   endfunction

   // Expected io_out for position c (0..6) within a frame of code cv:
   // c = 0..3 carry cv[3..0], c = 4..6 are the three gap cycles.
   function automatic logic [7:0] frame_exp(input logic [3:0] cv, input int c,
                                            input logic [1:0] f);
      if (c < 4) return mk(f, 2'(3 - c), 1'b0, 1'b1, 1'b1, cv[3 - c]);
      return mk(f, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endfunction

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst   = 1'b1;
      start = 1'($urandom_range(0, 1));
      code  = 4'($urandom_range(0, 15));
      rpt   = 1'($urandom_range(0, 1));
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (io_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_hold cyc %0d: got %h want 00", i, io_out);
         end
         start = 1'($urandom_range(0, 1));
         code  = 4'($urandom_range(0, 15));
         rpt   = 1'($urandom_range(0, 1));
      end
      rst   = 1'b0;
      start = 1'b0;
      code  = 4'h0;
      rpt   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (io_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_release cyc %0d: got %h want 00", i, io_out);
         end
      end
      exp_f = 2'd0;
   endtask

   task automatic test_single_frame();
      logic [7:0] tbl [0:8];
      tbl = '{8'h37, 8'h26, 8'h17, 8'h07, 8'h04, 8'h04, 8'h04, 8'h48, 8'h40};
      code  = 4'b1011;
      rpt   = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         if (i == 0) start = 1'b0;
         n_cmp++;
         if (io_out !== tbl[i]) begin
            n_err++;
            $display("FAIL single_frame cyc %0d: got %h want %h", i, io_out, tbl[i]);
         end
      end
      exp_f = 2'd1;
   endtask

   task automatic test_level_start();
      logic [7:0] e;
      int         dn;
      dn    = 0;
      code  = 4'b0101;
      start = 1'b1;
      for (int n = 0; n < 20; n++) begin
         step();
         if (n < 7)       e = frame_exp(code, n, exp_f);
         else if (n == 7) e = mk(exp_f + 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
         else             e = mk(exp_f + 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (io_out[3] === 1'b1) dn++;
         n_cmp++;
         if (io_out !== e) begin
            n_err++;
            $display("FAIL level_start cyc %0d: got %h want %h", n, io_out, e);
         end
      end
      n_cmp++;
      if (dn != 1) begin
         n_err++;
         $display("FAIL level_start_done_count: got %0d want 1", dn);
      end
      exp_f = exp_f + 2'd1;
      start = 1'b0;
      step();
      e = mk(exp_f, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (io_out !== e) begin
         n_err++;
         $display("FAIL level_start_release: got %h want %h", io_out, e);
      end
   endtask

   task automatic test_repeat();
      logic [3:0] cv;
      logic [7:0] e;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      cv    = 4'b0110;
      code  = cv;
      rpt   = 1'b1;
      start = 1'b1;
      for (int fr = 0; fr < 5; fr++) begin
         for (int c = 0; c < 7; c++) begin
            if (fr == 4 && c == 2) rpt = 1'b0;
            step();
            if (fr == 0 && c == 0) start = 1'b0;
            e = frame_exp(cv, c, 2'(fr));
            if (c == 0 && fr > 0) e[3] = 1'b1;
            n_cmp++;
            if (io_out !== e) begin
               n_err++;
               $display("FAIL repeat fr %0d cyc %0d: got %h want %h", fr, c, io_out, e);
            end
         end
      end
      step();
      e = mk(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (io_out !== e) begin
         n_err++;
         $display("FAIL repeat_last_done: got %h want %h", io_out, e);
      end
      step();
      e = mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (io_out !== e) begin
         n_err++;
         $display("FAIL repeat_idle: got %h want %h", io_out, e);
      end
      exp_f = 2'd1;
   endtask

   task automatic test_busy_changes();
      logic [3:0] cv;
      logic [7:0] e;
      cv    = 4'b1001;
      code  = cv;
      start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         step();
         if (c == 0) begin start = 1'b0; code = 4'b0000; end
         if (c == 1) start = 1'b1;
         if (c == 2) start = 1'b0;
         e = frame_exp(cv, c, exp_f);
         n_cmp++;
         if (io_out !== e) begin
            n_err++;
            $display("FAIL busy_changes cyc %0d: got %h want %h", c, io_out, e);
         end
      end
      step();
      e = mk(exp_f + 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (io_out !== e) begin
         n_err++;
         $display("FAIL busy_changes_done: got %h want %h", io_out, e);
      end
      exp_f = exp_f + 2'd1;
      for (int i = 0; i < 4; i++) begin
         step();
         e = mk(exp_f, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (io_out !== e) begin
            n_err++;
            $display("FAIL busy_changes_no_extra cyc %0d: got %h want %h", i, io_out, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] cv;
      logic [7:0] e;
      cv    = 4'b1100;
      code  = cv;
      start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         step();
         if (c == 0) start = 1'b0;
         e = frame_exp(cv, c, exp_f);
         n_cmp++;
         if (io_out !== e) begin
            n_err++;
            $display("FAIL b2b_first cyc %0d: got %h want %h", c, io_out, e);
         end
      end
      step();
      e = mk(exp_f + 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (io_out !== e) begin
         n_err++;
         $display("FAIL b2b_done: got %h want %h", io_out, e);
      end
      exp_f = exp_f + 2'd1;
      // Earliest restart: rise seen at the edge right after the done cycle.
      cv    = 4'b0011;
      code  = cv;
      start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         step();
         if (c == 0) start = 1'b0;
         e = frame_exp(cv, c, exp_f);
         n_cmp++;
         if (io_out !== e) begin
            n_err++;
            $display("FAIL b2b_second cyc %0d: got %h want %h", c, io_out, e);
         end
      end
      step();
      e = mk(exp_f + 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (io_out !== e) begin
         n_err++;
         $display("FAIL b2b_second_done: got %h want %h", io_out, e);
      end
      exp_f = exp_f + 2'd1;
   endtask

   task automatic test_reset_mid();
      logic [3:0] cv;
      logic [7:0] e;
      cv    = 4'b1010;
      code  = cv;
      start = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         if (c == 0) start = 1'b0;
         e = frame_exp(cv, c, exp_f);
         n_cmp++;
         if (io_out !== e) begin
            n_err++;
            $display("FAIL reset_mid_pre cyc %0d: got %h want %h", c, io_out, e);
         end
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (io_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_hold cyc %0d: got %h want 00", i, io_out);
         end
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (io_out !== 8'h00) begin
         n_err++;
         $display("FAIL reset_mid_release: got %h want 00", io_out);
      end
      cv    = 4'b1111;
      code  = cv;
      start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         step();
         if (c == 0) start = 1'b0;
         e = frame_exp(cv, c, 2'd0);
         n_cmp++;
         if (io_out !== e) begin
            n_err++;
            $display("FAIL reset_mid_frame cyc %0d: got %h want %h", c, io_out, e);
         end
      end
      step();
      n_cmp++;
      if (io_out !== 8'h48) begin
         n_err++;
         $display("FAIL reset_mid_done: got %h want 48", io_out);
      end
      exp_f = 2'd1;
   endtask

   // ------------------------------------------------------------------- main
   initial begin
      rst   = 1'b1;
      start = 1'b0;
      code  = 4'h0;
      rpt   = 1'b0;
      exp_f = 2'd0;
      test_reset();
      test_single_frame();
      test_level_start();
      test_repeat();
      test_busy_changes();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
